// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register.
// - pipe_state_e: occupancy state of a stage. The encoding equals the entry count, so the
//   state register drives the occupancy output directly.
// - Per-boundary default control/data widths for the classic 5-stage pipeline.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } pipe_state_e;

  // IF/ID: pc+4 and instruction word; one control bit (unused by the stage itself).
  localparam int unsigned IfIdCtrlW  = 1;
  localparam int unsigned IfIdDataW  = 64;
  // ID/EX: operand a, operand b, immediate, destination register.
  localparam int unsigned IdExCtrlW  = 8;
  localparam int unsigned IdExDataW  = 101;
  // EX/MEM: ALU result, store data, destination register; Wreg, Reg2reg, Wmem.
  localparam int unsigned ExMemCtrlW = 3;
  localparam int unsigned ExMemDataW = 69;
  // MEM/WB: memory data, ALU result, destination register; Wreg, Reg2reg.
  localparam int unsigned MemWbCtrlW = 2;
  localparam int unsigned MemWbDataW = 69;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: a control field and a data field.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset (clears both fields)
//   load              capture in_ctrl/in_data on the next rising edge
//   clear             zero the control field only; data is kept (wins over load)
//   in_ctrl, in_data  values to capture
//   ctrl, data        stored values
module pipe_slot #(
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DATA_W = 69
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
      data <= '0;
    end else if (clear) begin
      ctrl <= '0;
    end else if (load) begin
      ctrl <= in_ctrl;
      data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and bubble-safe control gating.
// Ports:
//   Clk, Clrn               clock, asynchronous active-low reset
//   flush                   drop every held entry (a take in the same cycle still completes)
//   in_valid/in_ready       upstream handshake; in_ctrl/in_data upstream payload
//   out_valid/out_ready     downstream handshake; out_ctrl (zero when no entry) / out_data
//   occupancy               number of held entries (0..2)
//   stall_cnt               saturating count of cycles with out_valid & ~out_ready
// SKID=1: head slot M plus skid slot S, in_ready is a register (no path from out_ready).
// SKID=0: head slot only, in_ready = ~out_valid | out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e state_q, state_d;

  logic              accept, take;
  logic              m_load, m_from_s, s_load;
  logic              rdy_q, rdy_d;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_in_ctrl;
  logic [DATA_W-1:0] m_data, s_data, m_in_data;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  // rdy_q is low in reset and rises on the first edge after release in both modes.
  if (SKID != 0) begin : g_rdy_reg
    assign in_ready = rdy_q;
  end else begin : g_rdy_comb
    assign in_ready = rdy_q & (~out_valid | out_ready);
  end

  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          m_load  = 1'b1;
        end
      end
      StOne: begin
        if (accept && take) begin
          m_load = 1'b1;
        end else if (accept) begin
          // Only reachable with SKID=1: SKID=0 never accepts into a full stage without a take.
          state_d = StTwo;
          s_load  = 1'b1;
        end else if (take) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (take) begin
          state_d  = StOne;
          m_load   = 1'b1;
          m_from_s = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush overrides everything; any accept this cycle is discarded.
    if (flush) begin
      state_d  = StEmpty;
      m_load   = 1'b0;
      m_from_s = 1'b0;
      s_load   = 1'b0;
    end
    rdy_d = (SKID != 0) ? (state_d != StTwo) : 1'b1;
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= StEmpty;
      rdy_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      stall_q <= stall_d;
    end
  end

  assign m_in_ctrl = m_from_s ? s_ctrl : in_ctrl;
  assign m_in_data = m_from_s ? s_data : in_data;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_m (
    .clk     (Clk),
    .rst_n   (Clrn),
    .load    (m_load),
    .clear   (flush),
    .in_ctrl (m_in_ctrl),
    .in_data (m_in_data),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_s (
      .clk     (Clk),
      .rst_n   (Clrn),
      .load    (s_load),
      .clear   (flush),
      .in_ctrl (in_ctrl),
      .in_data (in_data),
      .ctrl    (s_ctrl),
      .data    (s_data)
    );
  end else begin : g_no_skid
    assign s_ctrl = '0;
    assign s_data = '0;
  end

  // Gate control so a bubble can never trigger a register-file or memory write.
  assign out_ctrl  = m_ctrl & {CTRL_W{out_valid}};
  assign out_data  = m_data;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 2;
  localparam int unsigned NW = 4;

  logic Clk, Clrn;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SKID=1 instance
  logic          flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  // SKID=0 instance
  logic          z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [CW-1:0] z_in_ctrl, z_out_ctrl;
  logic [DW-1:0] z_in_data, z_out_data;
  logic [1:0]    z_occupancy;
  logic [15:0]   z_stall_cnt;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) dut (
    .Clk(Clk), .Clrn(Clrn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut0 (
    .Clk(Clk), .Clrn(Clrn), .flush(z_flush), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_ctrl(z_in_ctrl), .in_data(z_in_data), .out_valid(z_out_valid),
    .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
    .occupancy(z_occupancy), .stall_cnt(z_stall_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model for the SKID=1 instance: a FIFO of at most two entries.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t mq[$];
  int   mstall;
  bit   mrun;

  function automatic bit m_ready();
    return mrun && (mq.size() < 2);
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit   acc, tk;
    ent_t e;
    acc = in_valid && m_ready();
    tk  = (mq.size() != 0) && out_ready;
    if ((mq.size() != 0) && !out_ready && (mstall < 15)) mstall++;
    if (tk) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (acc) begin
      e.c = in_ctrl;
      e.d = in_data;
      mq.push_back(e);
    end
    mrun = 1'b1;
  endtask

  task automatic drive(input bit f, input bit iv, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input bit ordy);
    @(negedge Clk);
    flush     = f;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    Clrn = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11; in_data = 16'h1234;
    z_in_valid = 1'b1;
    mq.delete(); mstall = 0; mrun = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== 2'b00) begin failures++; $display("FAIL rst_ctrl got=%b exp=00", out_ctrl); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", out_data); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt); end
    checks++; if (z_in_ready !== 1'b0) begin failures++; $display("FAIL rst_z_ready got=%b exp=0", z_in_ready); end
    checks++; if (z_out_valid !== 1'b0) begin failures++; $display("FAIL rst_z_valid got=%b exp=0", z_out_valid); end
    @(negedge Clk);
    Clrn = 1'b1; in_valid = 1'b0; z_in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rel_in_ready got=%b exp=0", in_ready); end
    model_edge();
    @(posedge Clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rise_in_ready got=%b exp=1", in_ready); end
    checks++; if (z_in_ready !== 1'b1) begin failures++; $display("FAIL rise_z_ready got=%b exp=1", z_in_ready); end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 2'b11, DW'(k), 1'b1);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready); end
      if (k > 1) begin
        checks++; if (out_data !== DW'(k - 1)) begin failures++; $display("FAIL stream_data got=%0d exp=%0d", out_data, k - 1); end
        checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ got=%0d exp=1", occupancy); end
        checks++; if (out_ctrl !== 2'b11) begin failures++; $display("FAIL stream_ctrl got=%b exp=11", out_ctrl); end
      end
      model_edge();
    end
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    checks++; if (out_data !== DW'(8)) begin failures++; $display("FAIL stream_last got=%0d exp=8", out_data); end
    model_edge();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== 2'b00) begin failures++; $display("FAIL stream_bubble got=%b exp=00", out_ctrl); end
    model_edge();
  endtask

  task automatic test_skid();
    drive(1'b0, 1'b1, 2'b01, 16'hA, 1'b1);
    model_edge();
    drive(1'b0, 1'b1, 2'b01, 16'hB, 1'b0);
    checks++; if (out_data !== 16'hA) begin failures++; $display("FAIL skid_a got=%h exp=a", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_rdy1 got=%b exp=1", in_ready); end
    model_edge();
    drive(1'b0, 1'b1, 2'b01, 16'hC, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_rdy0 got=%b exp=0", in_ready); end
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL skid_occ got=%0d exp=2", occupancy); end
    checks++; if (out_data !== 16'hA) begin failures++; $display("FAIL skid_hold got=%h exp=a", out_data); end
    model_edge();
    drive(1'b0, 1'b1, 2'b01, 16'hC, 1'b1);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_regrdy got=%b exp=0", in_ready); end
    checks++; if (out_data !== 16'hA) begin failures++; $display("FAIL skid_a2 got=%h exp=a", out_data); end
    model_edge();
    drive(1'b0, 1'b1, 2'b01, 16'hC, 1'b1);
    checks++; if (out_data !== 16'hB) begin failures++; $display("FAIL skid_b got=%h exp=b", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_rdy2 got=%b exp=1", in_ready); end
    model_edge();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    checks++; if (out_data !== 16'hC) begin failures++; $display("FAIL skid_c got=%h exp=c", out_data); end
    model_edge();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_drain got=%b exp=0", out_valid); end
    checks++; if (stall_cnt !== NW'(2)) begin failures++; $display("FAIL skid_stall got=%0d exp=2", stall_cnt); end
    model_edge();
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 2'b11, 16'h11, 1'b0);
    model_edge();
    drive(1'b0, 1'b1, 2'b11, 16'h22, 1'b0);
    model_edge();
    drive(1'b1, 1'b1, 2'b11, 16'h33, 1'b0);
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
    model_edge();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== 2'b00) begin failures++; $display("FAIL flush_ctrl got=%b exp=00", out_ctrl); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    model_edge();
    drive(1'b0, 1'b1, 2'b10, 16'h44, 1'b1);
    model_edge();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    checks++; if (out_data !== 16'h44) begin failures++; $display("FAIL flush_next got=%h exp=44", out_data); end
    checks++; if (out_ctrl !== 2'b10) begin failures++; $display("FAIL flush_nctrl got=%b exp=10", out_ctrl); end
    model_edge();
  endtask

  task automatic test_stall_sat();
    drive(1'b0, 1'b1, 2'b01, 16'h99, 1'b1);
    model_edge();
    repeat (20) begin
      drive(1'b0, 1'b0, 2'b00, '0, 1'b0);
      model_edge();
    end
    drive(1'b0, 1'b0, 2'b00, '0, 1'b0);
    checks++; if (stall_cnt !== 4'hF) begin failures++; $display("FAIL stall_sat got=%0d exp=15", stall_cnt); end
    checks++; if (out_data !== 16'h99) begin failures++; $display("FAIL stall_data got=%h exp=99", out_data); end
    model_edge();
    drive(1'b1, 1'b0, 2'b00, '0, 1'b0);
    model_edge();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    checks++; if (stall_cnt !== 4'hF) begin failures++; $display("FAIL stall_hold got=%0d exp=15", stall_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_flush got=%b exp=0", out_valid); end
    model_edge();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 2'b11, 16'h55, 1'b0);
    model_edge();
    drive(1'b0, 1'b1, 2'b11, 16'h66, 1'b0);
    model_edge();
    drive(1'b0, 1'b1, 2'b11, 16'h77, 1'b1);
    #1 Clrn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL mid_occ got=%0d exp=0", occupancy); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL mid_stall got=%0d exp=0", stall_cnt); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL mid_data got=%h exp=0", out_data); end
    mq.delete(); mstall = 0; mrun = 1'b0;
    @(negedge Clk);
    Clrn = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    model_edge();
  endtask

  task automatic test_random();
    bit            exp_v;
    logic [CW-1:0] exp_c;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, CW'($urandom),
            DW'($urandom), $urandom_range(0, 9) < 6);
      exp_v = (mq.size() != 0);
      exp_c = exp_v ? mq[0].c : '0;
      checks++; if (in_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, in_ready, m_ready()); end
      checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, out_valid, exp_v); end
      checks++; if (occupancy !== 2'(mq.size())) begin failures++; $display("FAIL rnd_occ i=%0d got=%0d exp=%0d", i, occupancy, mq.size()); end
      checks++; if (out_ctrl !== exp_c) begin failures++; $display("FAIL rnd_ctrl i=%0d got=%b exp=%b", i, out_ctrl, exp_c); end
      if (exp_v) begin
        checks++; if (out_data !== mq[0].d) begin failures++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, out_data, mq[0].d); end
      end
      checks++; if (stall_cnt !== NW'(mstall)) begin failures++; $display("FAIL rnd_stall i=%0d got=%0d exp=%0d", i, stall_cnt, mstall); end
      model_edge();
    end
  endtask

  task automatic test_skid0();
    @(negedge Clk);
    z_flush = 1'b0; z_in_valid = 1'b1; z_in_ctrl = 2'b01; z_in_data = 16'd1; z_out_ready = 1'b0;
    #1;
    checks++; if (z_in_ready !== 1'b1) begin failures++; $display("FAIL s0_empty_rdy got=%b exp=1", z_in_ready); end
    @(negedge Clk);
    z_in_data = 16'd2;
    #1;
    checks++; if (z_in_ready !== 1'b0) begin failures++; $display("FAIL s0_full_rdy got=%b exp=0", z_in_ready); end
    checks++; if (z_out_data !== 16'd1) begin failures++; $display("FAIL s0_hold got=%0d exp=1", z_out_data); end
    checks++; if (z_occupancy !== 2'd1) begin failures++; $display("FAIL s0_occ got=%0d exp=1", z_occupancy); end
    @(negedge Clk);
    z_out_ready = 1'b1;
    #1;
    checks++; if (z_in_ready !== 1'b1) begin failures++; $display("FAIL s0_comb_rdy got=%b exp=1", z_in_ready); end
    checks++; if (z_out_data !== 16'd1) begin failures++; $display("FAIL s0_d1 got=%0d exp=1", z_out_data); end
    for (int k = 3; k <= 4; k++) begin
      @(negedge Clk);
      z_in_data = DW'(k);
      #1;
      checks++; if (z_out_data !== DW'(k - 1)) begin failures++; $display("FAIL s0_tput got=%0d exp=%0d", z_out_data, k - 1); end
      checks++; if (z_in_ready !== 1'b1) begin failures++; $display("FAIL s0_tput_rdy got=%b exp=1", z_in_ready); end
    end
    @(negedge Clk);
    z_in_valid = 1'b0;
    #1;
    checks++; if (z_out_data !== 16'd4) begin failures++; $display("FAIL s0_last got=%0d exp=4", z_out_data); end
    @(negedge Clk);
    #1;
    checks++; if (z_out_valid !== 1'b0) begin failures++; $display("FAIL s0_drain got=%b exp=0", z_out_valid); end
  endtask

  initial begin
    Clrn = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b1;
    z_flush = 1'b0; z_in_valid = 1'b0; z_in_ctrl = '0; z_in_data = '0; z_out_ready = 1'b1;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_stall_sat();
    test_reset_mid();
    test_random();
    test_skid0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
